mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch stage and the data-memory stage of the five-stage pipeline core.
- Serialises fetch and load/store requests over a req/gnt/rvalid memory handshake.
- Drives per-requester stall signals that feed the core's stall_f and stall_d freeze of the fetch and decode buffers.
- Default policy: data accesses win; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 32, address width of all ports.
DATA_W, 32, data width; strobe width is DATA_W/8.
STARVE_LIMIT, 4, consecutive data grants after which a pending fetch must win the next arbitration (range 1..15).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
if_req  in  1  fetch request; held with if_addr stable until if_valid.
if_addr  in  ADDR_W  fetch address (core pc_addr).
if_rdata  out  DATA_W  fetched instruction, valid when if_valid.
if_valid  out  1  one-cycle fetch completion pulse.
if_stall  out  1  fetch must hold.
d_req  in  1  data request; held with all d_* inputs stable until d_valid.
d_we  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  data address (core mem_write_addr).
d_wdata  in  DATA_W  store data.
d_wstrb  in  DATA_W/8  store byte enables.
d_rdata  out  DATA_W  load data, valid when d_valid.
d_valid  out  1  one-cycle data completion pulse; also fires for stores.
d_stall  out  1  memory stage must hold.
mem_req  out  1  memory request.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_wstrb  out  DATA_W/8  memory byte enables; all-zero on reads.
mem_gnt  in  1  memory accepted the request this cycle.
mem_rvalid  in  1  response this cycle; returned for both reads and writes.
mem_rdata  in  DATA_W  read data, qualified by mem_rvalid.

Behaviour:
- Reset values: FSM = IDLE, owner = data, starve counter = 0. All outputs 0.
- Reset mid-transaction: abandons the access. The memory is reset by the same rst_n, so no stale response is expected.
- FSM has three states: IDLE, REQ, RESP.
- IDLE:
  - If any request is pending, choose a winner and register mem_* from that requester. Next state is REQ.
  - Winner is data unless (if_req && cnt >= STARVE_LIMIT), in which case fetch wins.
- REQ:
  - mem_req = 1 and mem_* are held stable.
  - On mem_gnt, go to RESP and deassert mem_req next cycle.
  - mem_gnt && mem_rvalid in the same cycle completes directly, as in RESP.
- RESP:
  - Wait for mem_rvalid.
  - On mem_rvalid, pulse the owner's valid for that same cycle (combinational pass-through of mem_rdata to the owner's rdata; the other rdata reads 0), then return to IDLE.
- Minimum latency is request to valid in 2 cycles: IDLE, then REQ with gnt and rvalid together. There is no back-to-back issue; IDLE is always visited, a fixed one-cycle bubble.
- Stalls (combinational):
  - if_stall = if_req && !if_valid.
  - d_stall = d_req && !d_valid.
  - A requester is stalled while queued behind the other.
- Starve counter:
  - On a data grant with if_req high: increment, saturating at 15.
  - On a fetch grant: clear to 0.
  - On a data grant with if_req low: clear to 0.
- A request deasserted before its completion while the FSM is still IDLE is never issued. Once issued it completes; valid pulses regardless of the requester's current req.
- Simultaneous valid and new req from the same requester in one cycle: the new req is arbitrated in the following IDLE cycle.
- mem_wstrb is forced to 0 and mem_we to 0 for fetch grants.

Decomposition:
- Shared package (existing defs header): typedef enum arb_state_t {IDLE, REQ, RESP} and typedef enum arb_owner_t {OWN_IF, OWN_D}. The core stall wiring reuses these.
- No sub-module; the single-file FSM, counter and mux is natural, roughly 150–250 lines.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; mem_gnt on issue cycle, mem_rvalid=1 with rdata=0x00500093 two cycles after req → if_valid pulse, if_rdata=0x00500093, if_stall low that cycle.
- Contention: if_req and d_req both rise at cycle 0, d_we=1, d_addr=0x2000, wstrb=0xF → data issued first with mem_we=1; fetch issued after the d_valid pulse plus one IDLE cycle; if_stall high throughout.
- Starvation: d_req held continuously (re-requested every completion) with if_req=1 → exactly 4 data grants, then fetch grant; counter clears to 0.
- Delayed grant: mem_gnt held low 5 cycles → mem_req and mem_addr stable for all 5 cycles; no valid pulse until rvalid.
- Reset in RESP: assert rst_n=0 while waiting for rvalid → all outputs 0 asynchronously; after release, FSM idle, next request issues normally.
- Load data routing: d_we=0, d_addr=0x3004, mem_rdata=0xDEADBEEF → d_rdata=0xDEADBEEF with d_valid; if_rdata=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter and the core stall wiring.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam logic [3:0] STARVE_CNT_MAX = 4'd15;

    function automatic logic [3:0] starve_inc(input logic [3:0] v);
        return (v == STARVE_CNT_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one single-ported memory.
// Data wins by default; a starvation counter forces a pending fetch through.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    output logic                  if_stall,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  d_stall,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    arb_state_t          state_q, state_d;
    arb_owner_t          owner_q, owner_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic                done;
    logic                fetch_win;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        done        = 1'b0;
        fetch_win   = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // A lone fetch always wins; against data only once starved.
                    fetch_win = if_req && (!d_req || cnt_q >= LIMIT);
                    state_d   = REQ;
                    if (fetch_win) begin
                        owner_d     = OWN_IF;
                        cnt_d       = 4'd0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end else begin
                        owner_d     = OWN_D;
                        cnt_d       = if_req ? starve_inc(cnt_q) : 4'd0;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wstrb_d = d_we ? d_wstrb : '0;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_D;
            cnt_q       <= 4'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    // Completion is a same-cycle pass-through of the memory response.
    assign if_valid = done && (owner_q == OWN_IF);
    assign d_valid  = done && (owner_q == OWN_D);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign d_rdata  = d_valid  ? mem_rdata : '0;

    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req  && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation, stalls, reset and routing.
module tb_mem_port_arbiter;

    logic        clk, rst_n;
    logic        if_req;
    logic [31:0] if_addr, if_rdata;
    logic        if_valid, if_stall;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        d_valid, d_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_wstrb = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_stalls", {if_stall, d_stall}, 0);
        step(); step();
        rst_n = 1'b1;

        // Fetch only: gnt and rvalid together in REQ
        step();
        if_req = 1; if_addr = 32'h100;
        #1;
        chk("f_idle_stall", if_stall, 1);
        chk("f_idle_req", mem_req, 0);
        step();
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h00500093;
        #1;
        chk("f_mem_req", mem_req, 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we_strb", {mem_we, mem_wstrb}, 0);
        chk("f_if_valid", if_valid, 1);
        chk("f_if_rdata", if_rdata, 32'h00500093);
        chk("f_if_stall", if_stall, 0);
        chk("f_d_rdata", d_rdata, 0);
        step();
        if_req = 0; mem_gnt = 0; mem_rvalid = 0;
        #1;
        chk("f_back_idle", {mem_req, if_valid}, 0);

        // Contention: store first, fetch after d_valid plus one IDLE bubble
        step();
        if_req = 1; if_addr = 32'h104;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h11223344; d_wstrb = 4'hF;
        #1;
        chk("c_stalls", {if_stall, d_stall}, 2'b11);
        step();
        mem_gnt = 1; mem_rvalid = 0;
        #1;
        chk("c_data_addr", mem_addr, 32'h2000);
        chk("c_data_we", mem_we, 1);
        chk("c_data_wdata", mem_wdata, 32'h11223344);
        chk("c_data_wstrb", mem_wstrb, 4'hF);
        chk("c_no_valid", {if_valid, d_valid}, 0);
        step();
        mem_gnt = 0;
        #1;
        chk("c_resp_req", mem_req, 0);
        chk("c_resp_stalls", {if_stall, d_stall}, 2'b11);
        step();
        mem_rvalid = 1; mem_rdata = 32'h0;
        #1;
        chk("c_d_valid", d_valid, 1);
        chk("c_d_stall", d_stall, 0);
        chk("c_if_held", {if_stall, if_valid}, 2'b10);
        step();
        mem_rvalid = 0; d_req = 0;
        #1;
        chk("c_bubble", {mem_req, if_stall}, 2'b01);
        step();
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h00A00113;
        #1;
        chk("c_f_addr", mem_addr, 32'h104);
        chk("c_f_we_strb", {mem_we, mem_wstrb}, 0);
        chk("c_f_valid", if_valid, 1);
        chk("c_f_rdata", if_rdata, 32'h00A00113);
        step();
        if_req = 0; mem_gnt = 0; mem_rvalid = 0;

        // Starvation: 4 data grants, fetch, then data again (counter cleared)
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 0; d_addr = 32'h3000; d_wstrb = 4'h0;
        for (int k = 0; k < 6; k++) begin
            step();
            mem_gnt = 1; mem_rvalid = 1; mem_rdata = k;
            #1;
            chk("s_addr", mem_addr, (k == 4) ? 32'h200 : 32'h3000);
            chk("s_d_valid", d_valid, (k != 4));
            chk("s_if_valid", if_valid, (k == 4));
            step();
            mem_gnt = 0; mem_rvalid = 0;
            if (k == 5) begin if_req = 0; d_req = 0; end
            #1;
        end

        // Delayed grant: request held stable while gnt is low
        d_req = 1; d_we = 1; d_addr = 32'h4000; d_wdata = 32'hCAFEF00D; d_wstrb = 4'h3;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("g_hold_req", mem_req, 1);
            chk("g_hold_addr", mem_addr, 32'h4000);
            chk("g_hold_valid", d_valid, 0);
            step();
        end
        mem_gnt = 1;
        #1;
        chk("g_gnt_strb", mem_wstrb, 4'h3);
        chk("g_gnt_valid", d_valid, 0);
        step();
        mem_gnt = 0;
        #1;
        chk("g_resp_valid", d_valid, 0);
        step();
        mem_rvalid = 1;
        #1;
        chk("g_done_valid", d_valid, 1);
        step();
        mem_rvalid = 0; d_req = 0;

        // Reset while waiting in RESP
        d_req = 1; d_we = 0; d_addr = 32'h5000;
        step();
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        #1;
        chk("r_in_resp", {mem_req, d_stall}, 2'b01);
        chk("r_addr_before", mem_addr, 32'h5000);
        #2;
        rst_n = 0; d_req = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
        #1;
        chk("r_async_addr", mem_addr, 0);
        chk("r_async_outs", {mem_req, mem_we, d_valid, if_valid, d_stall, if_stall}, 0);
        chk("r_async_rdata", d_rdata, 0);
        step();
        rst_n = 1; mem_rvalid = 0;

        // Load routing after reset, issues normally
        d_req = 1; d_we = 0; d_addr = 32'h3004;
        #1;
        chk("l_idle", mem_req, 0);
        step();
        mem_gnt = 1;
        #1;
        chk("l_req", mem_req, 1);
        chk("l_addr", mem_addr, 32'h3004);
        chk("l_we_strb", {mem_we, mem_wstrb}, 0);
        step();
        mem_gnt = 0;
        step();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("l_d_valid", d_valid, 1);
        chk("l_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("l_if_rdata", if_rdata, 0);
        chk("l_if_valid", if_valid, 0);
        step();
        mem_rvalid = 0; d_req = 0;

        // Request withdrawn while still in IDLE is never issued
        if_req = 1; if_addr = 32'h300;
        #2;
        if_req = 0;
        step();
        chk("w_not_issued", mem_req, 0);
        step();
        chk("w_still_idle", mem_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
